// File: rtl/trim_seq_pkg.sv
// trim_seq_pkg: shared state encoding and bus widths for the oscillator trim sequencer.
package trim_seq_pkg;
  typedef enum logic [2:0] {IDLE, NEXT, RST, ARM, RUN, CAP} state_t;
  localparam int TRIM_W = 16;
  localparam int MSB_W  = 4;
  localparam int ODIV_W = 16;
endpackage

// File: rtl/trim_seq_if.sv
// trim_seq_if: link between the sequencer (master) and the shared freq_trim instance (slave).
interface trim_seq_if;
  import trim_seq_pkg::*;
  logic [2:0]        sel;
  logic [MSB_W-1:0]  msb;
  logic [ODIV_W-1:0] odiv;
  logic              rstb;
  logic              setb;
  logic              done;
  logic [TRIM_W-1:0] trim;
  modport master (output sel, msb, odiv, rstb, setb, input done, trim);
  modport slave  (input sel, msb, odiv, rstb, setb, output done, trim);
endinterface

// File: rtl/trim_seq_sync2.sv
// trim_sync2: two-flop synchroniser for the oclk-domain done flag.
module trim_sync2 (
  input  logic rclk,
  input  logic rstb,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge rclk or negedge rstb)
    if (!rstb) {q, m} <= 2'b00;
    else       {q, m} <= {m, d};
endmodule

// File: rtl/trim_seq.sv
// trim_seq: walks enabled oscillator channels through one shared freq_trim and stores results.
// Optional RUN timeout with per-channel error flags when TRIM_TIMEOUT_EN is defined.
module trim_seq
  import trim_seq_pkg::*;
#(
  parameter int NCH    = 6,
  parameter int SETTLE = 16,
  parameter int TO_CYC = 100000
) (
  input  logic                    rclk,
  input  logic                    rstb,
  input  logic                    start,
  input  logic [NCH-1:0]          ch_en,
  input  logic [MSB_W*NCH-1:0]    msb_cfg,
  input  logic [ODIV_W*NCH-1:0]   odiv_cfg,
  trim_seq_if.master              ft,
  output logic [TRIM_W*NCH-1:0]   trim_out,
  output logic                    busy,
  output logic                    seq_done,
  output logic [NCH-1:0]          err
);
  localparam logic [16:0] SET_M1 = 17'(SETTLE - 1);
  state_t         state;
  logic [NCH-1:0] left;
  logic [16:0]    cnt;
  logic           done_s, low_seen, found;
  logic [2:0]     pick;
  trim_sync2 u_sync (.rclk(rclk), .rstb(rstb), .d(ft.done), .q(done_s));
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (left[i]) begin
        found = 1'b1;
        pick  = 3'(i);
      end
  end
`ifdef TRIM_TIMEOUT_EN
  localparam logic [16:0] TO_M1 = 17'(TO_CYC - 1);
`else
  assign err = '0;
`endif
  // Mux outputs move only in NEXT, where rstb and setb to freq_trim are already low.
  always_ff @(posedge rclk or negedge rstb)
    if (!rstb) begin
      state    <= IDLE;
      left     <= '0;
      cnt      <= '0;
      low_seen <= 1'b0;
      busy     <= 1'b0;
      seq_done <= 1'b0;
      ft.sel   <= '0;
      ft.msb   <= '0;
      ft.odiv  <= '0;
      ft.rstb  <= 1'b0;
      ft.setb  <= 1'b0;
      for (int i = 0; i < NCH; i++)
        trim_out[TRIM_W*i +: TRIM_W] <= TRIM_W'(1) << msb_cfg[MSB_W*i +: MSB_W];
`ifdef TRIM_TIMEOUT_EN
      err <= '0;
`endif
    end else begin
      seq_done <= 1'b0;
      cnt      <= cnt + 17'd1;
      case (state)
        IDLE: if (start) begin
          left  <= ch_en;
          busy  <= 1'b1;
          state <= NEXT;
`ifdef TRIM_TIMEOUT_EN
          err <= '0;
`endif
        end
        NEXT: if (!found) begin
          seq_done <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end else begin
          left[pick] <= 1'b0;
          ft.sel     <= pick;
          ft.msb     <= msb_cfg[MSB_W*pick +: MSB_W];
          ft.odiv    <= odiv_cfg[ODIV_W*pick +: ODIV_W];
          cnt        <= '0;
          state      <= RST;
        end
        RST: if (cnt == SET_M1) begin
          ft.rstb <= 1'b1;
          cnt     <= '0;
          state   <= ARM;
        end
        ARM: if (cnt == SET_M1) begin
          ft.setb  <= 1'b1;
          cnt      <= '0;
          low_seen <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          low_seen <= low_seen | !done_s;
          if (done_s && low_seen) begin
            cnt   <= '0;
            state <= CAP;
          end
`ifdef TRIM_TIMEOUT_EN
          else if (cnt == TO_M1) begin
            err[ft.sel] <= 1'b1;
            ft.rstb     <= 1'b0;
            ft.setb     <= 1'b0;
            state       <= NEXT;
          end
`endif
        end
        CAP: if (cnt == 17'd1) begin
          trim_out[TRIM_W*ft.sel +: TRIM_W] <= ft.trim;
          ft.rstb <= 1'b0;
          ft.setb <= 1'b0;
          state   <= NEXT;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_trim_seq.sv
// tb_trim_seq: directed bench for trim_seq with a behavioural freq_trim and channel scoreboard.
// Define TRIM_TIMEOUT_EN to add the stopped-oscillator timeout scenario.
module tb_trim_seq;
  import trim_seq_pkg::*;
  localparam int NCH = 6;
  logic rclk = 1'b0, rstb = 1'b0, start = 1'b0;
  logic [NCH-1:0] ch_en = '0, err, stop_ch = '0, exp_err = '0;
  logic [MSB_W*NCH-1:0]  msb_cfg;
  logic [ODIV_W*NCH-1:0] odiv_cfg;
  logic [TRIM_W*NCH-1:0] trim_out;
  logic busy, seq_done, rstb_q = 1'b0;
  logic [22:0] mux_q = '0;
  int n_tests = 0, n_fail = 0, n_done = 0, n_rise = 0, ft_cnt = 0;
  int exp_ch[$];
  logic [TRIM_W-1:0] exp_trim [NCH];
  trim_seq_if ft_if ();
  trim_seq #(.NCH(NCH), .SETTLE(16), .TO_CYC(1000)) dut (
    .rclk(rclk), .rstb(rstb), .start(start), .ch_en(ch_en), .msb_cfg(msb_cfg),
    .odiv_cfg(odiv_cfg), .ft(ft_if), .trim_out(trim_out), .busy(busy),
    .seq_done(seq_done), .err(err));
  always #5 rclk = ~rclk;
  function automatic logic [15:0] tv(input logic [2:0] c, input logic [3:0] m, input logic [15:0] o);
    return (16'd1 << m) ^ o ^ {13'd0, c};
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  // Behavioural freq_trim: done rises a few cycles after setb, trim derived from the loaded bus.
  always @(posedge rclk)
    if (!ft_if.rstb) begin
      ft_cnt     <= 0;
      ft_if.done <= 1'b0;
    end else if (ft_if.setb && !stop_ch[ft_if.sel]) begin
      ft_cnt <= ft_cnt + 1;
      if (ft_cnt == 4 + int'(ft_if.sel)) begin
        ft_if.done <= 1'b1;
        ft_if.trim <= tv(ft_if.sel, ft_if.msb, ft_if.odiv);
      end
    end
  always @(negedge rclk) begin
    if (ft_if.rstb && !rstb_q) begin
      int c;
      n_rise++;
      c = exp_ch.size() > 0 ? exp_ch.pop_front() : -1;
      check("sel_order", 64'(ft_if.sel), 64'(c));
      check("busy_in_seq", 64'(busy), 64'd1);
      if (c >= 0) begin
        check("ft_msb", 64'(ft_if.msb), 64'(msb_cfg[4*c +: 4]));
        check("ft_odiv", 64'(ft_if.odiv), 64'(odiv_cfg[16*c +: 16]));
      end
    end
    if (rstb && {ft_if.sel, ft_if.msb, ft_if.odiv} !== mux_q)
      check("mux_quiet", 64'({ft_if.rstb, ft_if.setb}), 64'd0);
    mux_q  <= {ft_if.sel, ft_if.msb, ft_if.odiv};
    rstb_q <= ft_if.rstb;
    if (seq_done) n_done++;
  end
  task automatic set_mid();
    for (int i = 0; i < NCH; i++) exp_trim[i] = 16'd1 << msb_cfg[4*i +: 4];
    exp_err = '0;
  endtask
  task automatic do_reset();
    rstb = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge rclk);
    rstb = 1'b1;
    exp_ch.delete();
    set_mid();
    @(negedge rclk);
  endtask
  task automatic start_seq(input logic [NCH-1:0] en);
    exp_err = '0;
    for (int i = 0; i < NCH; i++)
      if (en[i]) begin
        exp_ch.push_back(i);
        if (stop_ch[i]) exp_err[i] = 1'b1;
        else exp_trim[i] = tv(3'(i), msb_cfg[4*i +: 4], odiv_cfg[16*i +: 16]);
      end
    ch_en = en;
    start = 1'b1;
    @(negedge rclk);
    start = 1'b0;
  endtask
  task automatic wait_seq(input string tag);
    int k = 0;
    while (!seq_done && k < 20000) begin
      @(negedge rclk);
      k++;
    end
    check({tag, "_seq_done"}, 64'(seq_done), 64'd1);
    @(negedge rclk);
  endtask
  task automatic check_res(input string tag);
    for (int i = 0; i < NCH; i++)
      check($sformatf("%s_trim%0d", tag, i), 64'(trim_out[16*i +: 16]), 64'(exp_trim[i]));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_all_visited"}, 64'(exp_ch.size()), 64'd0);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_rstb"}, 64'(ft_if.rstb), 64'd0);
    check({tag, "_setb"}, 64'(ft_if.setb), 64'd0);
    check({tag, "_mux"}, 64'({ft_if.sel, ft_if.msb, ft_if.odiv}), 64'd0);
    check({tag, "_busy"}, 64'({busy, seq_done}), 64'd0);
    check_res(tag);
  endtask
  initial begin
    int d0, r0, k;
    msb_cfg = {4'd11, 4'd11, 4'd11, 4'd7, 4'd7, 4'd7};
    for (int i = 0; i < NCH; i++) odiv_cfg[16*i +: 16] = 16'h1234 + 16'(i * 16'h0457);
    do_reset();
    check_reset("reset");
    d0 = n_done;
    start_seq(6'h3F);
    wait_seq("all");
    check_res("all");
    check("all_one_done", 64'(n_done - d0), 64'd1);
    for (int i = 0; i < NCH; i++) odiv_cfg[16*i +: 16] = 16'h0A5F ^ 16'(i * 16'h1111);
    do_reset();
    start_seq(6'b100100);
    wait_seq("sparse");
    check_res("sparse");
    r0 = n_rise;
    start_seq(6'h00);
    check("empty_busy1", 64'({busy, seq_done}), 64'b10);
    @(negedge rclk);
    check("empty_done2", 64'({busy, seq_done}), 64'b01);
    repeat (5) @(negedge rclk);
    check("empty_no_rstb", 64'(n_rise), 64'(r0));
    do_reset();
    d0 = n_done;
    start_seq(6'h3F);
    k = 0;
    while (!ft_if.setb && k < 200) begin
      @(negedge rclk);
      k++;
    end
    check("run_reached", 64'(ft_if.setb), 64'd1);
    ch_en = 6'h00;
    start = 1'b1;
    @(negedge rclk);
    start = 1'b0;
    ch_en = 6'h3F;
    wait_seq("restart");
    check_res("restart");
    check("restart_one_done", 64'(n_done - d0), 64'd1);
    start_seq(6'h3F);
    k = 0;
    while (!(ft_if.sel == 3'd3 && ft_if.setb) && k < 2000) begin
      @(negedge rclk);
      k++;
    end
    check("ch3_run", 64'({ft_if.sel, ft_if.setb}), 64'b0111);
    #2 rstb = 1'b0;
    exp_ch.delete();
    set_mid();
    #1 check_reset("abort");
    @(negedge rclk);
    rstb = 1'b1;
    @(negedge rclk);
    start_seq(6'h3F);
    wait_seq("after_abort");
    check_res("after_abort");
`ifdef TRIM_TIMEOUT_EN
    do_reset();
    stop_ch = 6'b000010;
    start_seq(6'h3F);
    wait_seq("timeout");
    check_res("timeout");
    stop_ch = '0;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not reach summary in time");
    $fatal(1);
  end
endmodule
